// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control unit for the multicycle RV32I datapath. A Moore FSM steps each
// instruction through Fetch / Decode / Execute / Memory / Writeback and drives
// every enable and mux select of the datapath. Supported instructions:
// lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset (FSM returns to FETCH)
//   opcode       instr[6:0] from the instruction register
//   funct3       instr[14:12]
//   funct7b5     instr[30]
//   zero         ALU zero flag (same-cycle, combinational)
//   pc_write     PC flop enable
//   adr_src      memory address mux select: 0=PC, 1=ALUOut
//   mem_write    data memory write enable
//   ir_write     instruction register / OldPC enable
//   reg_write    register file write enable
//   result_src   00=ALUOut, 01=mem data, 10=ALU result
//   alu_src_a    00=PC, 01=OldPC, 10=rs1 data
//   alu_src_b    00=rs2 data, 01=imm, 10=constant 4
//   imm_src      00=I, 01=S, 10=B, 11=J
//   alu_control  000 add, 001 sub, 010 and, 011 or, 101 slt
//   state        current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic [2:0]         alu_control,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_r;
    state_t     next_state_s;
    logic [1:0] alu_op_s;
    logic       pc_update_s;
    logic       branch_s;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; unknown opcodes and illegal encodings fall back to FETCH.
    always_comb begin
        next_state_s = FETCH;
        case (state_r)
            FETCH:    next_state_s = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_R:         next_state_s = EXECUTER;
                    OP_I:         next_state_s = EXECUTEI;
                    OP_BEQ:       next_state_s = BEQ;
                    OP_JAL:       next_state_s = JAL;
                    default:      next_state_s = FETCH;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW) begin
                    next_state_s = MEMREAD;
                end else begin
                    next_state_s = MEMWRITE;
                end
            end
            MEMREAD:  next_state_s = MEMWB;
            EXECUTER: next_state_s = ALUWB;
            EXECUTEI: next_state_s = ALUWB;
            JAL:      next_state_s = ALUWB;
            MEMWB:    next_state_s = FETCH;
            MEMWRITE: next_state_s = FETCH;
            ALUWB:    next_state_s = FETCH;
            BEQ:      next_state_s = FETCH;
            default:  next_state_s = FETCH;
        endcase
    end

    // Moore control decode: every output is a function of the current state only.
    always_comb begin
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op_s    = 2'b00;
        pc_update_s = 1'b0;
        branch_s    = 1'b0;
        case (state_r)
            FETCH: begin
                ir_write    = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                pc_update_s = 1'b1;
            end
            DECODE: begin
                // OldPC + imm precomputes the branch target into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op_s  = 2'b10;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op_s  = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op_s  = 2'b01;
                branch_s  = 1'b1;
            end
            JAL: begin
                // OldPC + 4 is the link value; ALUOut already holds the target.
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                pc_update_s = 1'b1;
            end
            default: begin
                adr_src = 1'b0;
            end
        endcase
    end

    // Branch is taken in the BEQ state itself, using the live zero flag.
    assign pc_write = pc_update_s | (branch_s & zero);

    // Immediate format follows the opcode directly.
    always_comb begin
        imm_src = 2'b00;
        case (opcode)
            OP_LW, OP_I: imm_src = 2'b00;
            OP_SW:       imm_src = 2'b01;
            OP_BEQ:      imm_src = 2'b10;
            OP_JAL:      imm_src = 2'b11;
            default:     imm_src = 2'b00;
        endcase
    end

    // ALU decoder; opcode[5] separates R-type sub from addi with instr[30] set.
    always_comb begin
        alu_control = 3'b000;
        case (alu_op_s)
            2'b00: alu_control = 3'b000;
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (funct7b5 & opcode[5]) begin
                            alu_control = 3'b001;
                        end else begin
                            alu_control = 3'b000;
                        end
                    end
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    assign state = STATE_W'(state_r);

endmodule
